// File: rtl/mmio_io_responder_pkg.sv
// ---------------------------------------------------------------------------
// io_map_pkg
// Shared definitions for the memory-mapped I/O window at 0xFFFFFC00-0xFFFFFFFF.
//   - register offsets within the window (byte offsets, word aligned)
//   - IO_BASE_HIGH: value of ALU result [31:10] that selects the I/O window;
//     the controller uses it to raise IORead/IOWrite
//   - seven-segment glyph table (active-low {dp,g,f,e,d,c,b,a})
//   - helpers: offset decode and hex-to-glyph lookup
// ---------------------------------------------------------------------------
package io_map_pkg;

   localparam logic [9:0]  OFS_SW       = 10'h000;
   localparam logic [9:0]  OFS_BTN      = 10'h004;
   localparam logic [9:0]  OFS_BTN_EDGE = 10'h008;
   localparam logic [9:0]  OFS_LED      = 10'h060;
   localparam logic [9:0]  OFS_SEG      = 10'h070;

   localparam logic [21:0] IO_BASE_HIGH = 22'h3FFFFF;

   localparam int NUM_BTN   = 5;
   localparam int NUM_DIGIT = 8;

   // Entry k is the glyph for hex digit k; decimal point is always off.
   localparam logic [15:0][7:0] SEG_GLYPH = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_SW,
      SEL_BTN,
      SEL_EDGE,
      SEL_LED,
      SEL_SEG
   } reg_sel_e;

   // Word access only: the byte-lane bits are masked off before decoding.
   function automatic reg_sel_e decode_ofs(input logic [9:0] addr);
      logic [9:0] ofs;
      reg_sel_e   sel;
      ofs = addr & 10'h3FC;
      sel = SEL_NONE;
      case (ofs)
         OFS_SW:       sel = SEL_SW;
         OFS_BTN:      sel = SEL_BTN;
         OFS_BTN_EDGE: sel = SEL_EDGE;
         OFS_LED:      sel = SEL_LED;
         OFS_SEG:      sel = SEL_SEG;
         default:      sel = SEL_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
      return SEG_GLYPH[nib];
   endfunction

endpackage

// File: rtl/mmio_io_responder_if.sv
// ---------------------------------------------------------------------------
// mmio_io_responder_if
// CPU-side I/O bus between the controller/ALU and the I/O responder.
//   io_read  : IORead strobe from the controller
//   io_write : IOWrite strobe from the controller
//   addr     : ALU result [9:0]; [1:0] are ignored (word access)
//   wdata    : store data
//   rdata    : load data, combinational in the responder
// master = CPU side, slave = responder side.
// ---------------------------------------------------------------------------
interface mmio_io_responder_if;
   logic        io_read;
   logic        io_write;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output io_read, output io_write, output addr, output wdata,
                   input  rdata);
   modport slave  (input  io_read, input  io_write, input  addr, input  wdata,
                   output rdata);
endinterface

// File: rtl/mmio_io_responder_debounce.sv
// ---------------------------------------------------------------------------
// io_debounce
// Single-bit 2-flop synchronizer followed by a stability counter.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   din   : raw asynchronous input
//   dout  : debounced level
// dout only changes after the synchronized input has disagreed with it for
// DB_CYCLES consecutive cycles; any agreement restarts the count.
// ---------------------------------------------------------------------------
module io_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             r_meta;
   logic             r_sync;
   logic             r_db;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_db   <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_meta <= din;
         r_sync <= r_meta;
         if (r_sync == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_db  <= ~r_db;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign dout = r_db;

endmodule

// File: rtl/mmio_io_responder.sv
// ---------------------------------------------------------------------------
// mmio_io_responder
// Board I/O behind the CPU's IORead/IOWrite window: switch and button
// readback, LED and seven-segment registers, and the multiplexed 8-digit
// seven-segment scan.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   bus      : CPU I/O bus (slave side); rdata is combinational
//   switch   : raw switches (asynchronous)
//   button   : raw buttons, active-high (asynchronous)
//   led      : LED drive (registered)
//   seg_an   : digit anodes, active-low (registered)
//   seg_cat  : segment cathodes {dp,g,f,e,d,c,b,a}, active-low (registered)
// ---------------------------------------------------------------------------
module mmio_io_responder
   import io_map_pkg::*;
#(
   parameter int DB_CYCLES   = 1_000_000,
   parameter int SCAN_CYCLES = 100_000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mmio_io_responder_if.slave      bus,
   input  logic [15:0]             switch,
   input  logic [NUM_BTN-1:0]      button,
   output logic [15:0]             led,
   output logic [7:0]              seg_an,
   output logic [7:0]              seg_cat
);

   localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

   logic [15:0]         r_sw_meta;
   logic [15:0]         r_sw_sync;
   logic [NUM_BTN-1:0]  w_btn_db;
   logic [NUM_BTN-1:0]  r_btn_db_d;
   logic [NUM_BTN-1:0]  w_btn_rise;
   logic [NUM_BTN-1:0]  r_edge_flags;
   logic [NUM_BTN-1:0]  w_edge_vis;
   logic [15:0]         r_led;
   logic [31:0]         r_seg_reg;
   logic [SCAN_W-1:0]   r_scan_cnt;
   logic [2:0]          r_digit;
   logic [7:0]          r_seg_an;
   logic [7:0]          r_seg_cat;
   logic [3:0]          w_nibble;
   reg_sel_e            w_sel;
   logic                w_rd_clear;

   // ---------------- button debouncers, one per bit ----------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (button[gi]),
            .dout  (w_btn_db[gi])
         );
      end
   endgenerate

   // ---------------- decode ----------------
   assign w_sel      = decode_ofs(bus.addr);
   // A simultaneous write keeps the read from consuming the edge flags.
   assign w_rd_clear = bus.io_read && !bus.io_write && (w_sel == SEL_EDGE);
   assign w_btn_rise = w_btn_db & ~r_btn_db_d;
   // A rising edge is visible in the very cycle btn_db goes high, before it
   // lands in the flag register; this also lets a rise win over a clear.
   assign w_edge_vis = r_edge_flags | w_btn_rise;

   // ---------------- register file, sync and edge logic ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_meta    <= '0;
         r_sw_sync    <= '0;
         r_btn_db_d   <= '0;
         r_edge_flags <= '0;
         r_led        <= '0;
         r_seg_reg    <= '0;
      end else begin
         r_sw_meta    <= switch;
         r_sw_sync    <= r_sw_meta;
         r_btn_db_d   <= w_btn_db;
         r_edge_flags <= (w_rd_clear ? '0 : r_edge_flags) | w_btn_rise;
         if (bus.io_write && (w_sel == SEL_LED)) begin
            r_led <= bus.wdata[15:0];
         end
         if (bus.io_write && (w_sel == SEL_SEG)) begin
            r_seg_reg <= bus.wdata;
         end
      end
   end

   // ---------------- read mux ----------------
   always_comb begin
      bus.rdata = '0;
      if (bus.io_read) begin
         case (w_sel)
            SEL_SW:   bus.rdata = {16'b0, r_sw_sync};
            SEL_BTN:  bus.rdata = {27'b0, w_btn_db};
            SEL_EDGE: bus.rdata = {27'b0, w_edge_vis};
            SEL_LED:  bus.rdata = {16'b0, r_led};
            SEL_SEG:  bus.rdata = r_seg_reg;
            default:  bus.rdata = '0;
         endcase
      end
   end

   // ---------------- seven-segment scan ----------------
   assign w_nibble = r_seg_reg[{r_digit, 2'b00} +: 4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         r_digit    <= '0;
         r_seg_an   <= 8'hFE;
         r_seg_cat  <= 8'hC0;
      end else begin
         if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 3'd1;   // 7 wraps to 0 naturally
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
         r_seg_an  <= ~(8'b1 << r_digit);
         r_seg_cat <= seg_glyph(w_nibble);
      end
   end

   assign led     = r_led;
   assign seg_an  = r_seg_an;
   assign seg_cat = r_seg_cat;

endmodule

// File: tb/tb_mmio_io_responder.sv
module tb_mmio_io_responder;

   localparam int DB   = 8;
   localparam int SCAN = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] switch = 16'h0;
   logic [4:0]  button = 5'h0;
   logic [15:0] led;
   logic [7:0]  seg_an;
   logic [7:0]  seg_cat;

   mmio_io_responder_if bus();

   mmio_io_responder #(.DB_CYCLES(DB), .SCAN_CYCLES(SCAN)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .switch  (switch),
      .button  (button),
      .led     (led),
      .seg_an  (seg_an),
      .seg_cat (seg_cat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [15:0] m_led, m_sw1, m_sw2;
   logic [31:0] m_seg;
   logic [4:0]  m_flags, m_db, m_db_prev, m_b1, m_b2;
   int          m_run [5];
   int          m_n;
   logic [7:0]  m_an, m_cat;

   function automatic logic [7:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
         4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
         4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
         4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
      endcase
   endfunction

   task automatic model_reset();
      m_led = 0; m_seg = 0; m_flags = 0; m_db = 0; m_db_prev = 0;
      m_sw1 = 0; m_sw2 = 0; m_b1 = 0; m_b2 = 0; m_n = 0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      m_an = 8'hFE; m_cat = 8'hC0;
   endtask

   function automatic logic [31:0] model_rdata();
      int ofs;
      ofs = int'(bus.addr[9:2]) * 4;
      if (!bus.io_read) return 32'h0;
      case (ofs)
         'h000:   return {16'h0, m_sw2};
         'h004:   return {27'h0, m_db};
         'h008:   return {27'h0, m_flags | (m_db & ~m_db_prev)};
         'h060:   return {16'h0, m_led};
         'h070:   return m_seg;
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs present before it.
   task automatic model_edge();
      int ofs, dig;
      logic clr;
      logic [4:0] rise;
      logic [31:0] old_seg;
      ofs = int'(bus.addr[9:2]) * 4;
      clr = bus.io_read && !bus.io_write && (ofs == 'h008);
      rise = m_db & ~m_db_prev;
      old_seg = m_seg;
      dig = (m_n / SCAN) % 8;
      m_flags = (clr ? 5'h0 : m_flags) | rise;
      m_db_prev = m_db;
      for (int i = 0; i < 5; i++) begin
         if (m_b2[i] == m_db[i]) m_run[i] = 0;
         else if (m_run[i] == DB - 1) begin m_db[i] = ~m_db[i]; m_run[i] = 0; end
         else m_run[i]++;
      end
      m_b2 = m_b1; m_b1 = button;
      m_sw2 = m_sw1; m_sw1 = switch;
      if (bus.io_write && ofs == 'h060) m_led = bus.wdata[15:0];
      if (bus.io_write && ofs == 'h070) m_seg = bus.wdata;
      m_an = ~(8'd1 << dig);
      m_cat = glyph(4'(old_seg >> (4 * dig)));
      m_n++;
   endtask

   task automatic set_bus(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
      bus.io_read = rd; bus.io_write = wr; bus.addr = a; bus.wdata = d;
   endtask

   // One clock: check rdata before the edge, then registered outputs after it.
   task automatic cyc();
      #1;
      check_val("rdata", bus.rdata, model_rdata());
      if (bus.io_read || bus.io_write)
         $display("txn t=%0t rd=%0b wr=%0b addr=%h wdata=%h rdata=%h",
                  $time, bus.io_read, bus.io_write, bus.addr, bus.wdata, bus.rdata);
      model_edge();
      @(posedge clk); #1;
      check_val("led", {16'h0, led}, {16'h0, m_led});
      check_val("seg_an", {24'h0, seg_an}, {24'h0, m_an});
      check_val("seg_cat", {24'h0, seg_cat}, {24'h0, m_cat});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] cat_tbl [8];
   logic [7:0] prev_an;
   int         run_len, changes, dig;
   logic [9:0] addrs [6];

   initial begin
      cat_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
      addrs = '{10'h000, 10'h004, 10'h008, 10'h060, 10'h070, 10'h0F0};
      set_bus(0, 0, 10'h0, 32'h0);
      switch = 16'hA5C3;
      model_reset();

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_led", {16'h0, led}, 32'h0);
      check_val("rst_an", {24'h0, seg_an}, 32'hFE);
      check_val("rst_cat", {24'h0, seg_cat}, 32'hC0);
      check_val("idle_rdata", bus.rdata, 32'h0);
      rst_n = 1'b1;
      model_reset();

      // ---- switch readback ----
      cyc(); cyc();
      set_bus(1, 0, 10'h000, 32'h0); #1;
      check_val("sw_read", bus.rdata, 32'h0000A5C3);
      cyc();

      // ---- LED write/read, unmapped write ----
      set_bus(0, 1, 10'h060, 32'hDEAD1234); cyc();
      check_val("led_write", {16'h0, led}, 32'h00001234);
      set_bus(1, 0, 10'h060, 32'h0); #1;
      check_val("led_read", bus.rdata, 32'h00001234);
      cyc();
      set_bus(0, 1, 10'h0F0, 32'hFFFFFFFF); cyc();
      check_val("led_unmapped", {16'h0, led}, 32'h00001234);
      set_bus(1, 0, 10'h0F0, 32'h0); #1;
      check_val("unmapped_read", bus.rdata, 32'h0);
      cyc();

      // ---- button bounce then stable press on bit 2 ----
      set_bus(1, 0, 10'h004, 32'h0);
      for (int r = 0; r < 3; r++) begin
         button[2] = 1'b1; repeat (3) cyc();
         button[2] = 1'b0; repeat (3) cyc();
      end
      button[2] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cyc(); #1;
         check_val("btn_rise_time", {31'h0, bus.rdata[2]}, {31'h0, k >= 10});
      end
      set_bus(1, 0, 10'h008, 32'h0); #1;
      check_val("edge_read", bus.rdata, 32'h4);
      cyc(); #1;
      check_val("edge_cleared", bus.rdata, 32'h0);
      cyc();

      // ---- edge arriving in the same cycle as a BTN_EDGE read ----
      set_bus(0, 0, 10'h0, 32'h0);
      button[0] = 1'b1;
      repeat (10) cyc();
      set_bus(1, 0, 10'h008, 32'h0); #1;
      check_val("edge_same_cycle", bus.rdata, 32'h1);
      cyc(); #1;
      check_val("edge_kept", bus.rdata, 32'h1);
      cyc(); #1;
      check_val("edge_gone", bus.rdata, 32'h0);
      cyc();
      set_bus(0, 0, 10'h0, 32'h0);
      button = 5'h0;
      repeat (12) cyc();

      // ---- seven-segment scan ----
      set_bus(0, 1, 10'h070, 32'h76543210); cyc();
      set_bus(0, 0, 10'h0, 32'h0);
      cyc(); cyc();
      prev_an = seg_an; run_len = 0; changes = 0;
      for (int k = 0; k < 72; k++) begin
         cyc();
         run_len++;
         if (seg_an != prev_an) begin
            changes++;
            check_val("an_step", {24'h0, seg_an}, {24'h0, {prev_an[6:0], prev_an[7]}});
            if (changes > 1) check_val("an_period", run_len, SCAN);
            prev_an = seg_an;
            run_len = 0;
         end
         dig = 0;
         for (int b = 0; b < 8; b++) if (!seg_an[b]) dig = b;
         check_val("cat_glyph", {24'h0, seg_cat}, {24'h0, cat_tbl[dig]});
      end
      check_val("an_changes", changes, 18);

      // ---- simultaneous read and write ----
      button[0] = 1'b1;
      repeat (14) cyc();
      set_bus(1, 1, 10'h008, 32'hFFFFFFFF); #1;
      check_val("rw_edge_read", bus.rdata, 32'h1);
      cyc();
      set_bus(1, 0, 10'h008, 32'h0); #1;
      check_val("rw_no_clear", bus.rdata, 32'h1);
      cyc(); #1;
      check_val("rw_clear_after", bus.rdata, 32'h0);
      set_bus(1, 1, 10'h060, 32'h0000ABCD); #1;
      check_val("rw_led_old", bus.rdata, 32'h00001234);
      cyc();
      check_val("rw_led_commit", {16'h0, led}, 32'h0000ABCD);

      // ---- randomized traffic against the model ----
      for (int k = 0; k < 400; k++) begin
         switch = 16'($urandom);
         for (int b = 0; b < 5; b++) if ($urandom_range(0, 11) == 0) button[b] = ~button[b];
         set_bus($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 addrs[$urandom_range(0, 5)] | 10'($urandom_range(0, 3)), $urandom);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
